// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  // Address width for a register count; a count of 1 still needs one address bit.
  function automatic int calc_aw(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, flush wipes; keeps a registered popcount.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             iss_v,
  input  logic [AW-1:0]    iss_rd,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      pend_cnt
);

  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_next;

  // Clear before set so an issue to the register being written back leaves it busy.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (we) busy_next[wa] = 1'b0;
      if (iss_v && (iss_rd != AW'(ZERO_REG))) busy_next[iss_rd] = 1'b1;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 1; i < NREGS; i++) begin
      cnt_next = cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_next;
      pend_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/reg_file_scb.sv
// Register file with x0 hardwired to zero, optional write-to-read forwarding and a pending-write scoreboard.
module reg_file_scb
  import reg_file_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = calc_aw(NREGS)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  output logic [AW:0]       pend_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != AW'(ZERO_REG))) begin
      regs[wa] <= wd;
    end
  end

  reg_scoreboard #(.NREGS(NREGS)) u_scb (
    .clk      (clk),
    .areset   (areset),
    .iss_v    (iss_v),
    .iss_rd   (iss_rd),
    .we       (we),
    .wa       (wa),
    .flush    (flush),
    .busy     (busy),
    .pend_cnt (pend_cnt)
  );

  // Read data is gated by reset so a forwarded wd cannot leak out while areset is low.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          nonzero;
    logic          hit;

    assign addr    = ra[p*AW +: AW];
    assign nonzero = (addr != AW'(ZERO_REG));
    assign hit     = (BYPASS != 0) && we && (wa == addr) && nonzero;

    assign rdata[p*XLEN +: XLEN] = (!areset || !nonzero) ? '0 :
                                   hit ? wd : regs[addr];
    assign rbusy[p] = nonzero && busy[addr] && !hit;
  end

endmodule

// File: tb/tb_reg_file_scb.sv
// Self-checking bench: two DUTs (forwarding on/off) driven alike and compared against a behavioural model.
module tb_reg_file_scb;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic              clk;
  logic              areset;
  logic              we;
  logic [AW-1:0]     wa;
  logic [XL-1:0]     wd;
  logic [NP*AW-1:0]  ra;
  logic              iss_v;
  logic [AW-1:0]     iss_rd;
  logic              flush;
  logic [NP*XL-1:0]  rdata_b, rdata_n;
  logic [NP-1:0]     rbusy_b, rbusy_n;
  logic [AW:0]       pend_b, pend_n;

  int errors = 0;
  int checks = 0;

  logic [XL-1:0] m_regs [NR];
  bit            m_busy [NR];

  reg_file_scb #(.XLEN(XL), .NREGS(NR), .NRD(NP), .BYPASS(1)) dut_byp (
    .clk(clk), .areset(areset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rdata(rdata_b), .rbusy(rbusy_b), .iss_v(iss_v), .iss_rd(iss_rd),
    .flush(flush), .pend_cnt(pend_b)
  );

  reg_file_scb #(.XLEN(XL), .NREGS(NR), .NRD(NP), .BYPASS(0)) dut_nob (
    .clk(clk), .areset(areset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rdata(rdata_n), .rbusy(rbusy_n), .iss_v(iss_v), .iss_rd(iss_rd),
    .flush(flush), .pend_cnt(pend_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: observed=0x%0h expected=0x%0h", tag, $time, observed, expected);
    end
  endtask

  function automatic logic [XL-1:0] expRdata(input int p, input bit byp);
    logic [AW-1:0] a;
    a = ra[p*AW +: AW];
    if (!areset || a == 0) return '0;
    if (byp && we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic expRbusy(input int p, input bit byp);
    logic [AW-1:0] a;
    a = ra[p*AW +: AW];
    if (!areset || a == 0) return 1'b0;
    if (byp && we && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [AW:0] expPend();
    int n;
    n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return (AW+1)'(n);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Architectural effect of one rising edge, taken straight from the write/issue/flush rules.
  task automatic modelEdge();
    if (!areset) return;
    if (we && wa != 0) m_regs[wa] = wd;
    if (flush) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    end else begin
      if (we) m_busy[wa] = 1'b0;
      if (iss_v && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic checkAll();
    for (int p = 0; p < NP; p++) begin
      checkOutput($sformatf("rdata_byp[%0d]", p), 64'(rdata_b[p*XL +: XL]), 64'(expRdata(p, 1'b1)));
      checkOutput($sformatf("rdata_nob[%0d]", p), 64'(rdata_n[p*XL +: XL]), 64'(expRdata(p, 1'b0)));
      checkOutput($sformatf("rbusy_byp[%0d]", p), 64'(rbusy_b[p]), 64'(expRbusy(p, 1'b1)));
      checkOutput($sformatf("rbusy_nob[%0d]", p), 64'(rbusy_n[p]), 64'(expRbusy(p, 1'b0)));
    end
    checkOutput("pend_byp", 64'(pend_b), 64'(expPend()));
    checkOutput("pend_nob", 64'(pend_n), 64'(expPend()));
  endtask

  task automatic applyStimulus(input logic w, input logic [AW-1:0] a, input logic [XL-1:0] d,
                               input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                               input logic iv, input logic [AW-1:0] ird, input logic fl);
    @(negedge clk);
    we = w; wa = a; wd = d; ra = {r1, r0};
    iss_v = iv; iss_rd = ird; flush = fl;
    #1 checkAll();
    @(posedge clk);
    modelEdge();
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    applyStimulus(1'b0, 5'd0, 32'h0, r0, r1, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    areset = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra = '0;
    iss_v = 1'b0; iss_rd = '0; flush = 1'b0;
    modelReset();
    #2 checkAll();
    @(negedge clk);
    areset = 1'b1;

    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    idle(5'd5, 5'd0);
    applyStimulus(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle(5'd0, 5'd5);

    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0);
    idle(5'd7, 5'd7);

    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, 5'd4, 1'b0);
    applyStimulus(1'b1, 5'd3, 32'h33333333, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
    idle(5'd3, 5'd4);

    applyStimulus(1'b1, 5'd9, 32'h99990001, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
    applyStimulus(1'b1, 5'd9, 32'h99990002, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
    idle(5'd9, 5'd4);

    for (int i = 10; i < 15; i++) applyStimulus(1'b0, 5'd0, 32'h0, 5'd10, 5'd14, 1'b1, 5'(i), 1'b0);
    applyStimulus(1'b1, 5'd11, 32'hF1F1F1F1, 5'd10, 5'd11, 1'b1, 5'd2, 1'b1);
    idle(5'd2, 5'd11);

    applyStimulus(1'b0, 5'd0, 32'h0, 5'd6, 5'd0, 1'b1, 5'd6, 1'b0);
    @(negedge clk);
    we = 1'b1; wa = 5'd6; wd = 32'h66666666; ra = {5'd5, 5'd6};
    iss_v = 1'b1; iss_rd = 5'd8; flush = 1'b0;
    #1 checkAll();
    #1 areset = 1'b0;
    modelReset();
    #1 checkAll();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    #1 checkAll();
    areset = 1'b1;
    we = 1'b0; iss_v = 1'b0;
    #1 checkAll();
    @(posedge clk);
    modelEdge();
    applyStimulus(1'b1, 5'd1, 32'h11111111, 5'd1, 5'd6, 1'b1, 5'd1, 1'b0);
    idle(5'd1, 5'd6);

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a, r0, r1, ird;
      a   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r0  = ($urandom_range(0, 1) != 0) ? a : 5'($urandom_range(0, 7));
      r1  = 5'($urandom_range(0, 31));
      ird = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, r0, r1,
                    1'($urandom_range(0, 1)), ird, ($urandom_range(0, 19) == 0));
    end
    idle(5'd0, 5'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_scb.md
REG_FILE_SCB -- requirements
Module: reg_file_scb

Interface
REQ-001 Parameter XLEN, default 32: data width in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers; SHALL be a power of two, at least 2. AW = log2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports, range 1 to 4.
REQ-004 Parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 areset  in  1  asynchronous, active-low reset.
REQ-007 we  in  1  write-port enable (writeback).
REQ-008 wa  in  AW  write address.
REQ-009 wd  in  XLEN  write data.
REQ-010 ra  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-011 rdata  out  NRD*XLEN  packed read data, combinational, same packing as ra.
REQ-012 rbusy  out  NRD  per-port flag: the addressed register has a pending write.
REQ-013 iss_v  in  1  issue strobe; marks the register at iss_rd as pending.
REQ-014 iss_rd  in  AW  destination register of the issued instruction.
REQ-015 flush  in  1  synchronous clear of all pending marks.
REQ-016 pend_cnt  out  AW+1  number of registers currently marked pending.

Function
REQ-017 Register 0 SHALL read as zero, ignore writes, and never be marked pending.
REQ-018 A write SHALL update register wa at the rising edge of clk when we=1 and wa!=0.
REQ-019 Reads SHALL be asynchronous with zero latency.
REQ-020 BYPASS=1: rdata port i SHALL return wd when we=1, wa=ra_i and ra_i!=0; otherwise it SHALL return the stored value.
REQ-021 BYPASS=0: rdata SHALL always return the stored value; a new value becomes visible the cycle after the write.
REQ-022 Pending set: at an edge with iss_v=1 and iss_rd!=0, the busy bit of iss_rd SHALL be set.
REQ-023 Pending clear: at an edge with we=1, the busy bit of wa SHALL be cleared.
REQ-024 Same edge, iss_rd=wa, both active: the busy bit SHALL end set (issue wins); wd is still written.
REQ-025 flush=1 SHALL clear all busy bits at the edge and take priority over iss_v; a write in the same cycle still completes.
REQ-026 BYPASS=1: rbusy_i = busy[ra_i] AND NOT (we AND wa=ra_i); BYPASS=0: rbusy_i = busy[ra_i]. rbusy_i SHALL be 0 when ra_i=0.
REQ-027 pend_cnt SHALL equal the population count of the busy bits, registered and updated in the same edge as the bits; it SHALL never exceed NREGS-1.
REQ-028 A write to a register that is not busy SHALL leave the busy state and pend_cnt unchanged.

Reset
REQ-029 areset=0 SHALL immediately clear all registers to 0, all busy bits to 0 and pend_cnt to 0, regardless of clk.
REQ-030 Outputs during reset: rdata all zero, rbusy all zero, pend_cnt=0.
REQ-031 Reset release SHALL be clean: the first edge after areset returns to 1 obeys REQ-018 to REQ-025 normally.

Structure
REQ-032 Package reg_file_pkg SHALL hold the default XLEN and NREGS, the constant ZERO_REG=0, and an AW derivation function (clog2).
REQ-033 Busy-bit and pend_cnt logic SHALL live in one sub-module, reg_scoreboard, with inputs iss_v, iss_rd, we, wa and flush.
REQ-034 The register array and forwarding muxes SHALL stay in reg_file_scb, generated per read port.

Verification
REQ-035 Reset, then write x5=0xDEADBEEF; next cycle ra0=5 -> rdata0=0xDEADBEEF; write x0=0x1234 -> reading ra=0 returns 0.
REQ-036 BYPASS=1: we=1, wa=7, wd=0xA5A5A5A5, ra1=7 in the same cycle -> rdata1=0xA5A5A5A5 combinationally. BYPASS=0, same stimulus -> old value, new value next cycle.
REQ-037 Issue x3 and x4 -> pend_cnt=2, rbusy high for ra=3; writeback x3 -> rbusy low in that cycle (BYPASS=1), pend_cnt=1 after the edge.
REQ-038 Same edge: iss_v=1, iss_rd=9, we=1, wa=9 -> busy[9] stays 1, register 9 updated, pend_cnt incremented by 1 only if x9 was not already busy.
REQ-039 Mark 5 registers pending, then flush=1 together with iss_v=1, iss_rd=2 -> pend_cnt=0 and rbusy all 0.
REQ-040 Assert areset mid-operation between clock edges with pending marks and nonzero registers -> all outputs 0 immediately; no write occurs at the next edge while areset=0.
